checkpoint_seq_monitor: RTL and testbench

CHECKPOINT_SEQ_MONITOR -- requirements
Module: checkpoint_seq_monitor

---
 rtl/checkpoint_seq_monitor.sv | 185 ++++++++++++++++++
 tb/tb_checkpoint_seq_monitor.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/checkpoint_seq_monitor.sv
// checkpoint_seq_monitor: watches a code bus for a configured sequence of
// checkpoint codes. Each code must be stable for STABLE samples before it is
// accepted. An optional strict mode flags out-of-order codes, and a per-stage
// timer flags a stalled sequence. The run ends in PASS or FAIL with a reason.
module checkpoint_seq_monitor #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int TMO_W  = 20,
  parameter int STABLE = 2,
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [WIDTH-1:0] checkbits,
  input  logic             start,
  input  logic             abort,
  input  logic             strict,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_idx,
  input  logic [WIDTH-1:0] cfg_code,
  input  logic [IDXW:0]    cfg_count,
  input  logic [TMO_W-1:0] tmo_limit,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_reason,
  output logic [IDXW-1:0]  stage,
  output logic             stage_hit
);

  // A filter length below one makes no sense; treat it as "accept every sample".
  localparam int STB = (STABLE < 1) ? 1 : STABLE;
  localparam int SCW = $clog2(STB + 1);
  localparam logic [SCW-1:0]   STB_N   = SCW'(STB);
  localparam logic [SCW-1:0]   SC_ONE  = SCW'(1);
  localparam logic [IDXW:0]    DEPTH_N = (IDXW + 1)'(DEPTH);
  localparam logic [IDXW:0]    N_ONE   = (IDXW + 1)'(1);
  localparam logic [IDXW-1:0]  ST_ONE  = IDXW'(1);
  localparam logic [TMO_W-1:0] TM_ONE  = TMO_W'(1);

  localparam logic [1:0] RSN_NONE  = 2'b00;
  localparam logic [1:0] RSN_TMO   = 2'b01;
  localparam logic [1:0] RSN_SEQ   = 2'b10;
  localparam logic [1:0] RSN_ABORT = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_PASS, ST_FAIL} state_t;

  state_t                       state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]  exp_q;
  logic                         strict_q, strict_d;
  logic [IDXW:0]                n_q, n_d;
  logic [IDXW-1:0]              stage_q, stage_d;
  logic [TMO_W-1:0]             timer_q, timer_d;
  logic [WIDTH-1:0]             samp_q, samp_d;
  logic [SCW-1:0]               scnt_q, scnt_d;
  logic [1:0]                   reason_q, reason_d;
  logic                         hit_q, hit_d;
  logic                         busy_q, done_q, pass_q;

  logic [SCW-1:0]               filt_cnt;
  logic                         accept;
  logic [IDXW:0]                n_clamp;
  logic                         cur_match, prev_match, last_stage;
  logic [TMO_W-1:0]             timer_inc;

  // Expected-code slots; rewritable only while no run is in progress.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_exp
      // One slot of the expected sequence.
      always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
          exp_q[gi] <= '0;
        end else if (cfg_we && !busy_q && (cfg_idx == IDXW'(gi))) begin
          exp_q[gi] <= cfg_code;
        end
      end
    end
  endgenerate

  // Stability filter: count identical consecutive samples, saturating at STABLE.
  always_comb begin
    filt_cnt = SC_ONE;
    if ((scnt_q != '0) && (checkbits == samp_q)) begin
      filt_cnt = (scnt_q == STB_N) ? STB_N : scnt_q + SC_ONE;
    end
    accept = (filt_cnt == STB_N);
  end

  // Sequence comparisons against the current and previous expected code.
  always_comb begin
    n_clamp    = (cfg_count > DEPTH_N) ? DEPTH_N : cfg_count;
    cur_match  = (checkbits == exp_q[stage_q]);
    prev_match = (checkbits == exp_q[stage_q - ST_ONE]);
    last_stage = ({1'b0, stage_q} == (n_q - N_ONE));
    timer_inc  = timer_q + TM_ONE;
  end

  // Next-state logic; abort beats match beats sequence error beats timeout.
  always_comb begin
    state_d  = state_q;
    strict_d = strict_q;
    n_d      = n_q;
    stage_d  = stage_q;
    timer_d  = timer_q;
    samp_d   = '0;
    scnt_d   = '0;
    reason_d = reason_q;
    hit_d    = 1'b0;
    case (state_q)
      ST_WAIT: begin
        samp_d  = checkbits;
        scnt_d  = filt_cnt;
        timer_d = timer_inc;
        if (abort) begin
          state_d  = ST_FAIL;
          reason_d = RSN_ABORT;
        end else if (accept && cur_match) begin
          hit_d   = 1'b1;
          timer_d = '0;
          if (last_stage) begin
            state_d = ST_PASS;
          end else begin
            stage_d = stage_q + ST_ONE;
          end
        end else if (accept && strict_q && (stage_q != '0) && !prev_match) begin
          state_d  = ST_FAIL;
          reason_d = RSN_SEQ;
        end else if ((tmo_limit != '0) && (timer_inc == tmo_limit)) begin
          state_d  = ST_FAIL;
          reason_d = RSN_TMO;
        end
      end
      default: begin
        if (start) begin
          strict_d = strict;
          n_d      = n_clamp;
          stage_d  = '0;
          timer_d  = '0;
          reason_d = RSN_NONE;
          state_d  = (n_clamp != '0) ? ST_WAIT : ST_PASS;
        end
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q  <= ST_IDLE;
      strict_q <= 1'b0;
      n_q      <= '0;
      stage_q  <= '0;
      timer_q  <= '0;
      samp_q   <= '0;
      scnt_q   <= '0;
      reason_q <= RSN_NONE;
      hit_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      strict_q <= strict_d;
      n_q      <= n_d;
      stage_q  <= stage_d;
      timer_q  <= timer_d;
      samp_q   <= samp_d;
      scnt_q   <= scnt_d;
      reason_q <= reason_d;
      hit_q    <= hit_d;
      busy_q   <= (state_d == ST_WAIT);
      done_q   <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass_q   <= (state_d == ST_PASS);
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_reason = reason_q;
  assign stage       = stage_q;
  assign stage_hit   = hit_q;

endmodule

// File: tb/tb_checkpoint_seq_monitor.sv
// Testbench for checkpoint_seq_monitor: directed runs push expected
// stage_hit / done events into queues; a negedge monitor pops and compares.
module tb_checkpoint_seq_monitor;
  localparam int WIDTH = 16;
  localparam int IDXW  = 2;
  localparam int TMO_W = 20;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic [WIDTH-1:0] checkbits = '0;
  logic             start = 1'b0;
  logic             start_b = 1'b0;
  logic             abort = 1'b0;
  logic             strict = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDXW-1:0]  cfg_idx = '0;
  logic [WIDTH-1:0] cfg_code = '0;
  logic [IDXW:0]    cfg_count = '0;
  logic [TMO_W-1:0] tmo_limit = '0;

  logic busy_a, done_a, pass_a, hit_a;
  logic [1:0] reason_a;
  logic [IDXW-1:0] stage_a;
  logic busy_b, done_b, pass_b, hit_b;
  logic [1:0] reason_b;
  logic [IDXW-1:0] stage_b;

  checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(4), .TMO_W(TMO_W), .STABLE(2)) dut (
    .clock(clk), .resetb(resetb), .checkbits(checkbits), .start(start), .abort(abort),
    .strict(strict), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_count(cfg_count), .tmo_limit(tmo_limit), .busy(busy_a), .done(done_a),
    .pass(pass_a), .fail_reason(reason_a), .stage(stage_a), .stage_hit(hit_a)
  );

  checkpoint_seq_monitor #(.WIDTH(WIDTH), .DEPTH(4), .TMO_W(TMO_W), .STABLE(3)) dut_s3 (
    .clock(clk), .resetb(resetb), .checkbits(checkbits), .start(start_b), .abort(abort),
    .strict(strict), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_count(cfg_count), .tmo_limit(tmo_limit), .busy(busy_b), .done(done_b),
    .pass(pass_b), .fail_reason(reason_b), .stage(stage_b), .stage_hit(hit_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit              is_done;
    logic            p;
    logic [1:0]      r;
    logic [IDXW-1:0] st;
    int              cy;
  } ev_t;

  typedef struct {
    logic            b;
    logic            d;
    logic            p;
    logic [1:0]      r;
    logic [IDXW-1:0] st;
  } snap_t;

  ev_t   qa[$];
  ev_t   qb[$];
  snap_t sq[$];
  int    total = 0;
  int    bad = 0;
  int    snap_no = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_event(input string who, input ev_t e, input bit is_done,
                             input logic p, input logic [1:0] r, input logic [IDXW-1:0] st);
    cmp({who, "_kind"}, int'(is_done), int'(e.is_done));
    cmp({who, "_stage"}, int'(st), int'(e.st));
    if (e.is_done) begin
      cmp({who, "_pass"}, int'(p), int'(e.p));
      cmp({who, "_reason"}, int'(r), int'(e.r));
    end
    if (e.cy >= 0) cmp({who, "_cycle"}, cyc, e.cy);
  endtask

  logic done_prev_a = 1'b0, done_prev_b = 1'b0;
  logic start_seen_a = 1'b0, start_seen_b = 1'b0;

  // Monitor: observes DUT events and snapshot requests away from the active edge.
  always @(negedge clk) begin
    ev_t   e;
    snap_t s;
    bit    ev_done;
    if (hit_a) begin
      $display("cyc %0d: A stage_hit stage=%0d", cyc, stage_a);
      cmp("a_hit_expected", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_event("a_hit", e, 1'b0, pass_a, reason_a, stage_a);
      end
    end
    ev_done = done_a && (!done_prev_a || start_seen_a);
    if (ev_done) begin
      $display("cyc %0d: A done pass=%0d reason=%0d stage=%0d", cyc, pass_a, reason_a, stage_a);
      cmp("a_done_expected", int'(qa.size() > 0), 1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check_event("a_done", e, 1'b1, pass_a, reason_a, stage_a);
      end
    end
    done_prev_a  = done_a;
    start_seen_a = start;

    if (hit_b) begin
      $display("cyc %0d: B stage_hit stage=%0d", cyc, stage_b);
      cmp("b_hit_expected", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_event("b_hit", e, 1'b0, pass_b, reason_b, stage_b);
      end
    end
    ev_done = done_b && (!done_prev_b || start_seen_b);
    if (ev_done) begin
      $display("cyc %0d: B done pass=%0d reason=%0d stage=%0d", cyc, pass_b, reason_b, stage_b);
      cmp("b_done_expected", int'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check_event("b_done", e, 1'b1, pass_b, reason_b, stage_b);
      end
    end
    done_prev_b  = done_b;
    start_seen_b = start_b;

    if (sq.size() > 0) begin
      s = sq.pop_front();
      snap_no++;
      $display("cyc %0d: snapshot %0d busy=%0d done=%0d pass=%0d reason=%0d stage=%0d hit=%0d",
               cyc, snap_no, busy_a, done_a, pass_a, reason_a, stage_a, hit_a);
      cmp($sformatf("snap%0d_busy", snap_no), int'(busy_a), int'(s.b));
      cmp($sformatf("snap%0d_done", snap_no), int'(done_a), int'(s.d));
      cmp($sformatf("snap%0d_pass", snap_no), int'(pass_a), int'(s.p));
      cmp($sformatf("snap%0d_reason", snap_no), int'(reason_a), int'(s.r));
      cmp($sformatf("snap%0d_stage", snap_no), int'(stage_a), int'(s.st));
      cmp($sformatf("snap%0d_hit", snap_no), int'(hit_a), 0);
      cmp($sformatf("snap%0d_pending_events", snap_no), qa.size() + qb.size(), 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [WIDTH-1:0] code, input int n);
    checkbits = code;
    repeat (n) tick();
  endtask

  task automatic cfg(input int idx, input logic [WIDTH-1:0] code);
    cfg_idx  = IDXW'(idx);
    cfg_code = code;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic go(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  task automatic go_b(output int s);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    s = cyc;
  endtask

  task automatic push_a(input bit is_done, input logic p, input logic [1:0] r,
                        input logic [IDXW-1:0] st, input int cy);
    ev_t e;
    e.is_done = is_done; e.p = p; e.r = r; e.st = st; e.cy = cy;
    qa.push_back(e);
  endtask

  task automatic push_b(input bit is_done, input logic p, input logic [1:0] r,
                        input logic [IDXW-1:0] st, input int cy);
    ev_t e;
    e.is_done = is_done; e.p = p; e.r = r; e.st = st; e.cy = cy;
    qb.push_back(e);
  endtask

  task automatic snap(input logic b, input logic d, input logic p,
                      input logic [1:0] r, input logic [IDXW-1:0] st);
    snap_t s;
    s.b = b; s.d = d; s.p = p; s.r = r; s.st = st;
    sq.push_back(s);
    tick();
  endtask

  initial begin
    int s;
    resetb = 1'b0;
    repeat (2) tick();
    snap(0, 0, 0, 2'd0, 0);
    resetb = 1'b1;
    tick();
    snap(0, 0, 0, 2'd0, 0);

    cfg(0, 16'hAB40);
    cfg(1, 16'hAB41);
    cfg(2, 16'hAB51);
    cfg_count = 3'd3;
    tmo_limit = 20'd1000;
    strict    = 1'b0;

    // Lenient pass with an ignored stray code.
    go(s);
    push_a(0, 0, 2'd0, 1, s + 2);
    push_a(0, 0, 2'd0, 2, s + 12);
    push_a(0, 0, 2'd0, 2, s + 17);
    push_a(1, 1, 2'd0, 2, s + 17);
    hold(16'hAB40, 5); hold(16'h1234, 5); hold(16'hAB41, 5); hold(16'hAB51, 5);
    hold(16'h0000, 3);
    snap(0, 1, 1, 2'd0, 2);

    // Strict mode sequence error.
    strict = 1'b1;
    go(s);
    push_a(0, 0, 2'd0, 1, s + 2);
    push_a(1, 0, 2'd2, 1, s + 7);
    hold(16'hAB40, 5); hold(16'h1234, 2);
    hold(16'h0000, 3);
    snap(0, 1, 0, 2'd2, 1);
    strict = 1'b0;

    // Timeout exactly tmo_limit cycles after entering WAIT.
    tmo_limit = 20'd50;
    go(s);
    push_a(1, 0, 2'd1, 0, s + 50);
    hold(16'h0000, 55);
    snap(0, 1, 0, 2'd1, 0);

    // Match accepted on the timeout cycle wins.
    cfg_count = 3'd1;
    go(s);
    push_a(0, 0, 2'd0, 0, s + 50);
    push_a(1, 1, 2'd0, 0, s + 50);
    hold(16'h0000, 48); hold(16'hAB40, 4); hold(16'h0000, 2);
    snap(0, 1, 1, 2'd0, 0);

    // Glitch filter on the STABLE=3 instance.
    tmo_limit = 20'd0;
    go_b(s);
    push_b(0, 0, 2'd0, 0, s + 9);
    push_b(1, 1, 2'd0, 0, s + 9);
    hold(16'h0000, 2); hold(16'hAB40, 2); hold(16'h0000, 2); hold(16'hAB40, 3);
    hold(16'h0000, 2);
    snap(0, 1, 1, 2'd0, 0);

    // Empty sequence passes on the start edge.
    cfg_count = 3'd0;
    go(s);
    push_a(1, 1, 2'd0, 0, s);
    hold(16'h0000, 3);
    snap(0, 1, 1, 2'd0, 0);

    // Oversized count clamps to DEPTH stages.
    cfg(3, 16'hAB77);
    cfg_count = 3'd7;
    tmo_limit = 20'd1000;
    go(s);
    push_a(0, 0, 2'd0, 1, s + 2);
    push_a(0, 0, 2'd0, 2, s + 5);
    push_a(0, 0, 2'd0, 3, s + 8);
    push_a(0, 0, 2'd0, 3, s + 11);
    push_a(1, 1, 2'd0, 3, s + 11);
    hold(16'hAB40, 3); hold(16'hAB41, 3); hold(16'hAB51, 3); hold(16'hAB77, 3);
    hold(16'h0000, 3);
    snap(0, 1, 1, 2'd0, 3);

    // Configuration write while busy is dropped.
    cfg_count = 3'd1;
    go(s);
    push_a(0, 0, 2'd0, 0, s + 3);
    push_a(1, 1, 2'd0, 0, s + 3);
    cfg(0, 16'hBEEF);
    hold(16'hAB40, 2);
    hold(16'h0000, 3);
    snap(0, 1, 1, 2'd0, 0);

    // Abort (with a simultaneous start) beats the final match.
    go(s);
    push_a(1, 0, 2'd3, 0, s + 2);
    checkbits = 16'hAB40;
    tick();
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    hold(16'h0000, 3);
    snap(0, 1, 0, 2'd3, 0);

    // Reset mid-WAIT clears outputs at once and wipes the stored codes.
    cfg_count = 3'd3;
    go(s);
    hold(16'h0000, 3);
    snap(1, 0, 0, 2'd0, 0);
    resetb = 1'b0;
    snap(0, 0, 0, 2'd0, 0);
    tick();
    resetb = 1'b1;
    tick();
    tmo_limit = 20'd20;
    cfg_count = 3'd1;
    go(s);
    push_a(1, 0, 2'd1, 0, s + 20);
    hold(16'hAB40, 25);
    snap(0, 1, 0, 2'd1, 0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
